neuron_vector_player: RTL and testbench
=======================================

Name: neuron_vector_player

Overview:
Parametrised multi-lane stimulus sequencer for neuron-level benches and on-chip self-test. Holds NUM_CH vector lanes (data, tap, ..., bias as the last lane) in internal memories loaded through a write port. Plays them to a downstream neuron over a valid/ready handshake, with the last lane delayed by BIAS_DELAY indices. Supports one-shot and continuous loop modes, abort, and length/pass reporting.

Parameters:
DATA_W, 32, width of one lane word (float_24_8 packed)
NUM_CH, 3, number of lanes; lane NUM_CH-1 is the delayed (bias) lane
DEPTH, 1000, words per lane memory
ADDR_W, 10, index width; must satisfy 2^ADDR_W >= DEPTH
BIAS_DELAY, 1, index lag applied to lane NUM_CH-1 (0 = aligned)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begin playback (accepted in IDLE or DONE)
abort  in  1  pulse; stop playback, return to IDLE
loop_en  in  1  sampled at start; 1 = wrap continuously
length  in  ADDR_W+1  vectors per pass, sampled at start
mem_we  in  1  lane memory write strobe
mem_ch  in  $clog2(NUM_CH)  lane select for write
mem_addr  in  ADDR_W  write address
mem_wdata  in  DATA_W  write data
out_valid  out  1  vector valid
out_ready  in  1  downstream accepts vector
out_data  out  NUM_CH*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
out_last  out  1  high with the final vector of each pass
out_index  out  ADDR_W  index of the vector on out_data
busy  out  1  high in RUN
done  out  1  high in DONE
pass_count  out  16  completed passes since start, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; memory contents undefined (not cleared).
- States: IDLE, RUN, DONE. abort has priority over start; in any state, abort goes to IDLE on the next edge with out_valid=0, done=0.
- start in IDLE/DONE: latch L = min(length, DEPTH) and loop_en, clear pass_count, idx=0.
  - L=0: go to DONE directly; no beat is produced.
  - Else: go to RUN; out_data/out_index/out_last loaded for idx 0 and out_valid=1 on the next cycle (1-cycle start latency).
- start while in RUN is ignored.
- Lane mapping for index i:
  - lanes 0..NUM_CH-2 = mem[k][i].
  - Lane NUM_CH-1 = mem[NUM_CH-1][i-BIAS_DELAY] when i >= BIAS_DELAY, else 0.
- Outputs are registered and reloaded only on a transfer (out_valid & out_ready). While out_ready=0, out_data, out_index and out_last hold stable. No bubbles under continuous ready: one vector per cycle.
- On transfer of index i < L-1: next vector is i+1.
- On transfer of index L-1 (out_last=1), pass_count increments, saturating at 16'hFFFF.
  - loop_en=0: go to DONE with out_valid=0 on the next cycle.
  - loop_en=1: wrap to idx 0 with no bubble.
- out_last = (out_index == L-1) while out_valid.
- DONE: done=1 and busy=0; pass_count is held.
- Memory writes:
  - Accepted only when not busy. mem_we in RUN is dropped.
  - Writes with mem_ch >= NUM_CH or mem_addr >= DEPTH are dropped.
  - A write in IDLE is visible to a start issued the following cycle.
- Index arithmetic is modulo-free. idx never exceeds L-1, and the bias read address never goes negative (zero substitution).

Test Plan:
- Load lane0[i]=i, lane1[i]=0x100+i, lane2[i]=0x200+i, i=0..9. Start with length=4, loop_en=0, ready=1. Expect beats {0,0x100,0}, {1,0x101,0x200}, {2,0x102,0x201}, {3,0x103,0x202} on consecutive cycles; out_last on beat 3; then done=1, pass_count=1.
- Same load, ready toggled 1,0,0,1,... Expect out_data held stable during ready=0, no dropped or duplicated index, still exactly 4 beats.
- length=3, loop_en=1, ready=1 for 10 cycles. Expect index sequence 0,1,2,0,1,2,...; out_last every third beat; pass_count reaches 3. Then abort: IDLE, out_valid=0, done=0.
- length=0 start: done=1 on the next cycle, zero beats. length=1500 with DEPTH=1000: exactly 1000 beats, last index 999.
- mem_we during RUN to lane0 addr1 with 0xDEAD: the beat at index 1 still shows the old value. The same write in IDLE, followed by a new start, shows 0xDEAD at index 1.
- Assert reset mid-RUN at index 2: outputs go to 0 immediately (asynchronously). After release the block sits in IDLE until start, and a new start replays from index 0.

Source files
------------

// File: rtl/neuron_vector_player.sv
// rtl/neuron_vector_player.sv - multi-lane vector sequencer with delayed bias lane
module neuron_vector_player #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 1000,
  parameter int ADDR_W     = 10,
  parameter int BIAS_DELAY = 1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic [ADDR_W:0]          length,
  input  logic                     mem_we,
  input  logic [CH_W-1:0]          mem_ch,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              pass_count
);

  localparam int              LAST    = NUM_CH - 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BD_L    = (ADDR_W+1)'(BIAS_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  state_t                   state;
  logic                     loop_q;
  logic [ADDR_W-1:0]        last_q;
  logic                     xfer;
  logic                     start_ok;
  logic [ADDR_W:0]          len_clip;
  logic [ADDR_W-1:0]        len_last;
  logic [ADDR_W-1:0]        nxt_idx;
  logic                     nxt_last;
  logic [ADDR_W:0]          bias_diff;
  logic [NUM_CH*DATA_W-1:0] nxt_data;
  logic                     wr_ok;

  assign xfer     = out_valid & out_ready;
  assign start_ok = start & (state != S_RUN);
  assign len_clip = (length > DEPTH_L) ? DEPTH_L : length;
  assign len_last = len_clip[ADDR_W-1:0] - ADDR_W'(1);
  assign wr_ok    = mem_we & ~busy & ({1'b0, mem_ch} < (CH_W+1)'(NUM_CH))
                    & ({1'b0, mem_addr} < DEPTH_L);

  // Lane memories: written only while not playing, read asynchronously below
  always_ff @(posedge clk) begin
    if (wr_ok) mem[mem_ch][mem_addr] <= mem_wdata;
  end

  // Next index to present: 0 on start or wrap, else the successor of the current one
  always_comb begin
    nxt_idx = '0;
    if (!start_ok && (out_index != last_q)) nxt_idx = out_index + ADDR_W'(1);
    nxt_last  = (nxt_idx == (start_ok ? len_last : last_q));
    // Negative bias address shows up as the borrow bit; those indices read zero
    bias_diff = {1'b0, nxt_idx} - BD_L;
  end

  // Gather the vector for nxt_idx from all lanes, bias lane lagging by BIAS_DELAY
  always_comb begin
    nxt_data = '0;
    for (int k = 0; k < LAST; k++) nxt_data[k*DATA_W +: DATA_W] = mem[k][nxt_idx];
    nxt_data[LAST*DATA_W +: DATA_W] = bias_diff[ADDR_W] ? '0 : mem[LAST][bias_diff[ADDR_W-1:0]];
  end

  // Playback FSM with registered outputs; output regs reload only on start or transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      loop_q     <= 1'b0;
      last_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            loop_q     <= loop_en;
            last_q     <= len_last;
            pass_count <= '0;
            if (len_clip == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              done      <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= nxt_data;
              out_index <= nxt_idx;
              out_last  <= nxt_last;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (out_index == last_q) begin
              if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            end
            if ((out_index == last_q) && !loop_q) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data  <= nxt_data;
              out_index <= nxt_idx;
              out_last  <= nxt_last;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_vector_player.sv
// tb/tb_neuron_vector_player.sv - scoreboard bench for neuron_vector_player
module tb_neuron_vector_player;

  localparam int DW = 32;
  localparam int NC = 3;
  localparam int DP = 1000;
  localparam int AW = 10;
  localparam int BD = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW:0]   length = '0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_ch = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NC*DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;
  logic [15:0]   pass_count;

  neuron_vector_player #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .ADDR_W(AW), .BIAS_DELAY(BD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop_en(loop_en),
    .length(length), .mem_we(mem_we), .mem_ch(mem_ch), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_index(out_index),
    .busy(busy), .done(done), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [AW-1:0]    idx;
    logic             last;
  } beat_t;

  beat_t       exp_q[$];
  logic [DW-1:0] lm [NC][DP];
  int vectors = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected beats for one pass of length L, straight from the lane mapping rule
  task automatic push_pass(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {(i >= BD) ? lm[2][i-BD] : 32'h0, lm[1][i], lm[0][i]};
      b.idx  = AW'(i);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: every presented vector must match the queue head; pop on transfer
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {out_index, out_last}, 128'h0);
      end else begin
        if ({out_data, out_index, out_last} !== {exp_q[0].data, exp_q[0].idx, exp_q[0].last})
          chk("beat", {out_data, out_index, out_last}, {exp_q[0].data, exp_q[0].idx, exp_q[0].last});
        else
          vectors++;
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge
  task automatic mem_write(input int ch, input int addr, input logic [DW-1:0] d, input bit running);
    mem_we = 1'b1; mem_ch = 2'(ch); mem_addr = AW'(addr); mem_wdata = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
    if (!running && ch < NC && addr < DP) lm[ch][addr] = d;
  endtask

  task automatic do_start(input int len, input bit lp);
    length = (AW+1)'(len); loop_en = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0, 2: random
  task automatic run_until_done(input int mode, input int budget, input int exp_passes);
    int n = 0;
    while (!done && n < budget) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    chk("done", {done, busy}, {1'b1, 1'b0});
    chk("beats_left", exp_q.size(), 0);
    chk("pass_count", pass_count, exp_passes);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_data, out_last, out_index, busy, done, pass_count}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Random fill of every lane, then the fixed pattern over 0..9
    for (int k = 0; k < NC; k++)
      for (int i = 0; i < DP; i++) mem_write(k, i, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_write(0, i, 32'(i), 1'b0);
      mem_write(1, i, 32'h100 + 32'(i), 1'b0);
      mem_write(2, i, 32'h200 + 32'(i), 1'b0);
    end
    // Out-of-range writes must be dropped
    mem_write(3, 0, 32'hBAD0, 1'b0);
    mem_write(0, 1000, 32'hBAD1, 1'b0);
    mem_write(1, 1023, 32'hBAD2, 1'b0);

    // One-shot, length 4, continuous ready
    push_pass(4);
    out_ready = 1'b1;
    do_start(4, 1'b0);
    chk("first_beat_valid", out_valid, 1'b1);
    run_until_done(0, 20, 1);

    // Same pass with ready 1,0,0 pattern
    push_pass(4);
    do_start(4, 1'b0);
    run_until_done(1, 40, 1);

    // Loop mode, length 3, ten transfers then abort
    push_pass(3); push_pass(3); push_pass(3); push_pass(3);
    out_ready = 1'b1;
    do_start(3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("loop_pass_count", pass_count, 16'd3);
    chk("loop_beats_left", exp_q.size(), 2);
    out_ready = 1'b0;
    do_abort();
    chk("abort_state", {out_valid, done, busy}, 3'b000);
    exp_q.delete();

    // Zero length: straight to DONE, no beat
    do_start(0, 1'b0);
    chk("len0_done", {done, busy, out_valid}, 3'b100);
    @(posedge clk); #1;
    chk("len0_pass_count", pass_count, 16'd0);

    // Over-long request clips to DEPTH
    push_pass(DP);
    do_start(1500, 1'b0);
    run_until_done(2, 5000, 1);

    // Write while running is dropped
    push_pass(4);
    out_ready = 1'b1;
    do_start(4, 1'b0);
    mem_write(0, 1, 32'hDEAD, 1'b1);
    run_until_done(0, 20, 1);

    // Same write while idle is seen by the next start
    do_abort();
    mem_write(0, 1, 32'hDEAD, 1'b0);
    push_pass(4);
    do_start(4, 1'b0);
    run_until_done(0, 20, 1);

    // Asynchronous reset in the middle of a pass
    push_pass(10);
    out_ready = 1'b1;
    do_start(10, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_index", out_index, 10'd2);
    #2 reset = 1'b1;
    #1 chk("async_reset", {out_valid, out_data, out_last, out_index, busy, done, pass_count}, '0);
    exp_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", {out_valid, busy, done}, 3'b000);
    push_pass(4);
    do_start(4, 1'b0);
    run_until_done(0, 20, 1);

    // Random one-shot passes with random backpressure
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 25);
      push_pass(len);
      do_start(len, 1'b0);
      run_until_done(2, 200, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
